// File: rtl/loop_sweep_pkg.sv
// Shared types and default sizing for the loop stimulus sweeper.
package loop_sweep_pkg;

    localparam int IN_W_DEF       = 8;
    localparam int OBS_W_DEF      = 14;
    localparam int SETTLE_CYC_DEF = 4;
    localparam int HOLD_CYC_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_OBSERVE = 3'd2,
        ST_RECORD  = 3'd3,
        ST_DONE    = 3'd4
    } sweep_state_t;

    typedef struct packed {
        logic [IN_W_DEF-1:0] pat;
        logic                unstable;
        logic                mismatch;
    } sweep_result_t;

endpackage

// File: rtl/obs_stability_window.sv
// Captures a baseline of the observed nets and flags any later deviation
// from it until the next clear.
module obs_stability_window #(
    parameter int OBS_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample,
    input  logic [OBS_W-1:0] obs,
    output logic             unstable
);

    logic [OBS_W-1:0] base_q, base_d;
    logic             unst_q, unst_d;
    logic             diff_s;

    // Compare written as if/else so an unknown bit falls into the "changed" branch.
    always_comb begin
        if (obs == base_q) begin
            diff_s = 1'b0;
        end else begin
            diff_s = 1'b1;
        end
    end

    // Baseline capture on clear, sticky accumulation on sample.
    always_comb begin
        base_d = base_q;
        unst_d = unst_q;
        if (clear) begin
            base_d = obs;
            unst_d = 1'b0;
        end else if (sample) begin
            unst_d = unst_q | diff_s;
        end else begin
            unst_d = unst_q;
        end
    end

    // Window state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= {OBS_W{1'b0}};
            unst_q <= 1'b0;
        end else begin
            base_q <= base_d;
            unst_q <= unst_d;
        end
    end

    assign unstable = unst_q;

endmodule

// File: rtl/loop_stim_sweeper.sv
// Sweeps all input patterns of the loop netlist, measures stability of its
// internal nets per pattern and scores the result against its own prediction.
module loop_stim_sweeper
    import loop_sweep_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int OBS_W      = OBS_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [IN_W-1:0] stim,
    input  logic [OBS_W-1:0] obs,
    input  logic            osc_pred,
    output logic            busy,
    output logic            done,
    output logic            res_valid,
    output logic [IN_W-1:0] res_pat,
    output logic            res_unstable,
    output logic            res_mismatch,
    output logic [IN_W:0]   osc_cnt,
    output logic [IN_W:0]   mism_cnt,
    output logic [IN_W-1:0] first_osc_pat,
    output logic            first_osc_vld
);

    localparam int PH_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0] HOLD_LAST   = PH_W'(HOLD_CYC - 1);
    localparam logic [PH_W-1:0] PH_ONE      = {{(PH_W-1){1'b0}}, 1'b1};
    localparam logic [IN_W-1:0] PAT_ONE     = {{(IN_W-1){1'b0}}, 1'b1};
    localparam logic [IN_W-1:0] PAT_LAST    = {IN_W{1'b1}};

    sweep_state_t    state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [IN_W-1:0] pat_q, pat_d;
    logic            busy_q, busy_d, done_q, done_d, pred_q, pred_d;
    logic            rv_q, rv_d, runst_q, runst_d, rmism_q, rmism_d;
    logic [IN_W-1:0] rpat_q, rpat_d, fpat_q, fpat_d;
    logic            fvld_q, fvld_d;
    logic [IN_W:0]   osc_q, osc_d, mism_q, mism_d;
    logic            win_clear_s, win_sample_s, win_unstable_s, mism_s;

    obs_stability_window #(.OBS_W(OBS_W)) u_window (
        .clk      (clk),
        .rst      (rst),
        .clear    (win_clear_s),
        .sample   (win_sample_s),
        .obs      (obs),
        .unstable (win_unstable_s)
    );

    // The first observe cycle takes the baseline; the rest accumulate deviations.
    always_comb begin
        win_clear_s  = 1'b0;
        win_sample_s = 1'b0;
        if (state_q == ST_OBSERVE) begin
            win_clear_s  = (phase_q == {PH_W{1'b0}});
            win_sample_s = (phase_q != {PH_W{1'b0}});
        end else begin
            win_clear_s  = 1'b0;
            win_sample_s = 1'b0;
        end
    end

    assign mism_s = win_unstable_s ^ pred_q;

    // Sweep sequencing, result formatting and statistics.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pat_d   = pat_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pred_d  = pred_q;
        rv_d    = 1'b0;
        rpat_d  = rpat_q;
        runst_d = runst_q;
        rmism_d = rmism_q;
        osc_d   = osc_q;
        mism_d  = mism_q;
        fpat_d  = fpat_q;
        fvld_d  = fvld_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    phase_d = {PH_W{1'b0}};
                    pat_d   = {IN_W{1'b0}};
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    osc_d   = {(IN_W+1){1'b0}};
                    mism_d  = {(IN_W+1){1'b0}};
                    fpat_d  = {IN_W{1'b0}};
                    fvld_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SETTLE: begin
                if (phase_q == SETTLE_LAST) begin
                    state_d = ST_OBSERVE;
                    phase_d = {PH_W{1'b0}};
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            ST_OBSERVE: begin
                if (phase_q == HOLD_LAST) begin
                    state_d = ST_RECORD;
                    phase_d = {PH_W{1'b0}};
                    pred_d  = osc_pred;
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            ST_RECORD: begin
                rv_d    = 1'b1;
                rpat_d  = pat_q;
                runst_d = win_unstable_s;
                rmism_d = mism_s;
                osc_d   = osc_q + {{IN_W{1'b0}}, win_unstable_s};
                mism_d  = mism_q + {{IN_W{1'b0}}, mism_s};
                if (win_unstable_s && !fvld_q) begin
                    fpat_d = pat_q;
                    fvld_d = 1'b1;
                end else begin
                    fvld_d = fvld_q;
                end
                if (pat_q == PAT_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                    pat_d   = pat_q + PAT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= {PH_W{1'b0}};
            pat_q   <= {IN_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pred_q  <= 1'b0;
            rv_q    <= 1'b0;
            rpat_q  <= {IN_W{1'b0}};
            runst_q <= 1'b0;
            rmism_q <= 1'b0;
            osc_q   <= {(IN_W+1){1'b0}};
            mism_q  <= {(IN_W+1){1'b0}};
            fpat_q  <= {IN_W{1'b0}};
            fvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pat_q   <= pat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pred_q  <= pred_d;
            rv_q    <= rv_d;
            rpat_q  <= rpat_d;
            runst_q <= runst_d;
            rmism_q <= rmism_d;
            osc_q   <= osc_d;
            mism_q  <= mism_d;
            fpat_q  <= fpat_d;
            fvld_q  <= fvld_d;
        end
    end

    assign stim          = pat_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign res_valid     = rv_q;
    assign res_pat       = rpat_q;
    assign res_unstable  = runst_q;
    assign res_mismatch  = rmism_q;
    assign osc_cnt       = osc_q;
    assign mism_cnt      = mism_q;
    assign first_osc_pat = fpat_q;
    assign first_osc_vld = fvld_q;

endmodule
